mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified memory between the instruction-fetch (IF) and data (MEM) stages.
//  Grants one requester at a time and latches that request into registered memory-side outputs.
//  Routes the single in-order response back to the owning requester.
//  Data beats fetch, except that a starvation counter forces a fetch grant; a response timeout flags hung memory.
// PARAMETERS
//  AW            32   address width
//  DW            32   data width (DW/8 byte strobes)
//  STARVE_LIMIT  4    consecutive data grants while if_req is pending before fetch is forced; range 1..15
//  TIMEOUT       255  cycles in ISSUE+WAIT before abort; 0 disables; range 0..65535
// PORTS
//  clk        in   1     clock, rising edge
//  rst        in   1     asynchronous active-high reset
//  if_req     in   1     fetch request; held until if_gnt
//  if_addr    in   AW    fetch address
//  if_gnt     out  1     fetch accepted (1-cycle pulse)
//  if_rvalid  out  1     fetch response valid (1-cycle pulse)
//  d_req      in   1     data request; held until d_gnt
//  d_we       in   1     1 = store, 0 = load
//  d_addr     in   AW    data address
//  d_wdata    in   DW    store data
//  d_wstrb    in   DW/8  store byte strobes
//  d_gnt      out  1     data accepted (1-cycle pulse)
//  d_rvalid   out  1     data response valid (also acknowledges stores)
//  rdata      out  DW    response data, shared; qualified by if_rvalid or d_rvalid
//  m_req      out  1     memory request
//  m_we       out  1     memory write enable
//  m_addr     out  AW    memory address
//  m_wdata    out  DW    memory write data
//  m_wstrb    out  DW/8  memory strobes; all zero for fetches and loads
//  m_gnt      in   1     memory accepted the request this cycle
//  m_rvalid   in   1     memory response/ack; at most one outstanding
//  m_rdata    in   DW    memory read data
//  busy       out  1     state != IDLE
//  timeout_err out 1     1-cycle pulse on abort
// BEHAVIOUR
//  Reset: all outputs 0, state=IDLE, owner=IF, starve_cnt=0, to_cnt=0. Reset mid-transaction discards it.
//  States and transitions:
//   IDLE->ISSUE when any req; ISSUE->WAIT on m_gnt; WAIT->IDLE on m_rvalid; ISSUE/WAIT->IDLE on timeout.
//  IDLE arbitration is combinational: if_gnt/d_gnt = winner & state==IDLE.
//   Winner is d_req, unless (if_req & starve_cnt==STARVE_LIMIT) or !d_req.
//  Grant edge: latch addr/we/wdata/wstrb/owner into the m_* registers; m_req=1 from the next cycle.
//   For a fetch, m_we=0 and m_wstrb=0.
//  ISSUE: m_req and payload held stable until m_gnt. m_req deasserts on the m_gnt edge.
//  WAIT: on m_rvalid, register rdata<=m_rdata, pulse owner rvalid in the next cycle, and return to IDLE.
//   A new grant may occur in that same rvalid cycle.
//  Minimum latency: req at cycle 0 -> m_req at 1 -> m_gnt at 1 -> m_rvalid at 2 -> owner rvalid at 3.
//  starve_cnt:
//   +1 (saturating at STARVE_LIMIT) on each data grant while if_req=1.
//   Cleared on a fetch grant, or when a data grant occurs with if_req=0.
//  to_cnt:
//   Cleared on entering ISSUE; +1 each cycle in ISSUE/WAIT.
//   When to_cnt==TIMEOUT (TIMEOUT!=0): drop m_req, go IDLE, pulse timeout_err.
//   In the next cycle, pulse owner rvalid with rdata = all ones.
//  m_rvalid in IDLE or ISSUE (stray or post-timeout) is ignored and does not change state.
//  m_gnt and timeout in the same cycle: timeout wins and the response is ignored.
//  No combinational path from m_* inputs to m_* outputs.
//  if_gnt/d_gnt depend only on state, the req inputs and starve_cnt.
// TESTING
//  1. Only if_req, addr 0x100, memory gnt same cycle, rvalid +1 with 0x00500093
//     -> if_gnt@0, m_req@1, if_rvalid@3, rdata=0x00500093.
//  2. if_req and d_req together, d_we=1, addr 0x2000, wdata 0xCAFEF00D, strb 0xF
//     -> d_gnt first, m_we=1 with that payload; if_gnt in the d_rvalid cycle.
//  3. d_req held for 6 transactions, if_req held, STARVE_LIMIT=4
//     -> 4 data grants, then 1 fetch grant, then data resumes.
//  4. TIMEOUT=8, memory never asserts m_gnt
//     -> m_req held 8 cycles, timeout_err pulse, owner rvalid with rdata=0xFFFFFFFF, busy=0.
//  5. rst asserted during WAIT, then a stray m_rvalid after release
//     -> all outputs 0 immediately, stray response ignored, state IDLE.
//  6. m_gnt stalled 3 cycles in ISSUE with random input changes on d_*
//     -> m_addr/m_wdata/m_wstrb stable, equal to the granted values.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one single-ported unified memory between the instruction
//            fetch port and the data port. One transaction at a time is
//            granted, latched into registered memory-side outputs and its
//            single in-order response is routed back to the owning port.
//            Data beats fetch until a starvation counter forces a fetch; a
//            response timeout aborts a hung transaction.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic            clk,
    input  logic            rst,
    // instruction fetch port
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    // data port
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_wstrb,
    output logic            d_gnt,
    output logic            d_rvalid,
    // shared response data
    output logic [DW-1:0]   rdata,
    // memory side
    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_wstrb,
    input  logic            m_gnt,
    input  logic            m_rvalid,
    input  logic [DW-1:0]   m_rdata,
    // status
    output logic            busy,
    output logic            timeout_err
);

    localparam logic [1:0]  c_IDLE       = 2'd0;
    localparam logic [1:0]  c_ISSUE      = 2'd1;
    localparam logic [1:0]  c_WAIT       = 2'd2;

    localparam logic [3:0]  c_STARVE_MAX = 4'(STARVE_LIMIT);
    localparam bit          c_TO_EN      = (TIMEOUT != 0);
    // The abort is taken on the edge where the counter would reach TIMEOUT,
    // so m_req is visible for exactly TIMEOUT cycles when never accepted.
    localparam logic [15:0] c_TO_LAST    = 16'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic        r_owner_if;
    logic [3:0]  r_starve_cnt;
    logic [15:0] r_to_cnt;

    logic        w_idle;
    logic        w_fetch_win;
    logic        w_data_win;
    logic        w_timeout;

    // Arbitration: data wins unless fetch has been starved long enough or
    // there is no data request at all.
    assign w_idle      = (r_state == c_IDLE);
    assign w_fetch_win = if_req & (~d_req | (r_starve_cnt == c_STARVE_MAX));
    assign w_data_win  = d_req & ~w_fetch_win;
    assign if_gnt      = w_fetch_win & w_idle;
    assign d_gnt       = w_data_win & w_idle;
    assign busy        = ~w_idle;
    assign w_timeout   = c_TO_EN && !w_idle && (r_to_cnt == c_TO_LAST);

    // Transaction sequencer: grant latch, memory handshake, response return
    // and timeout abort, all with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_owner_if   <= 1'b1;
            r_starve_cnt <= 4'd0;
            r_to_cnt     <= 16'd0;
            m_req        <= 1'b0;
            m_we         <= 1'b0;
            m_addr       <= '0;
            m_wdata      <= '0;
            m_wstrb      <= '0;
            rdata        <= '0;
            if_rvalid    <= 1'b0;
            d_rvalid     <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            if_rvalid   <= 1'b0;
            d_rvalid    <= 1'b0;
            timeout_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (if_gnt) begin
                        r_owner_if   <= 1'b1;
                        m_we         <= 1'b0;
                        m_addr       <= if_addr;
                        m_wstrb      <= '0;
                        r_starve_cnt <= 4'd0;
                        m_req        <= 1'b1;
                        r_to_cnt     <= 16'd0;
                        r_state      <= c_ISSUE;
                    end else if (d_gnt) begin
                        r_owner_if   <= 1'b0;
                        m_we         <= d_we;
                        m_addr       <= d_addr;
                        m_wdata      <= d_wdata;
                        // loads never drive byte strobes
                        m_wstrb      <= d_we ? d_wstrb : '0;
                        if (!if_req) begin
                            r_starve_cnt <= 4'd0;
                        end else if (r_starve_cnt != c_STARVE_MAX) begin
                            r_starve_cnt <= r_starve_cnt + 4'd1;
                        end
                        m_req        <= 1'b1;
                        r_to_cnt     <= 16'd0;
                        r_state      <= c_ISSUE;
                    end
                end
                c_ISSUE, c_WAIT: begin
                    r_to_cnt <= r_to_cnt + 16'd1;
                    if (w_timeout) begin
                        // abort wins over a same-cycle m_gnt or m_rvalid
                        m_req       <= 1'b0;
                        timeout_err <= 1'b1;
                        rdata       <= '1;
                        if (r_owner_if) if_rvalid <= 1'b1;
                        else            d_rvalid  <= 1'b1;
                        r_state     <= c_IDLE;
                    end else if (r_state == c_ISSUE) begin
                        if (m_gnt) begin
                            m_req   <= 1'b0;
                            r_state <= c_WAIT;
                        end
                    end else if (m_rvalid) begin
                        rdata <= m_rdata;
                        if (r_owner_if) if_rvalid <= 1'b1;
                        else            d_rvalid  <= 1'b1;
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    m_req   <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed, self-checking bench for mem_port_arbiter. A
//            transaction-level reference model is compared against the DUT
//            every cycle, plus hand-computed literal checks per scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int c_LIMIT = 4;
    localparam int c_TO    = 8;

    logic        clk;
    logic        rst;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] rdata;
    logic        m_req, m_we, m_gnt, m_rvalid;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic        busy, timeout_err;

    mem_port_arbiter #(
        .AW(32), .DW(32), .STARVE_LIMIT(c_LIMIT), .TIMEOUT(c_TO)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .rdata(rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .busy(busy), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus knobs (written by the main sequence at negedge+2)
    // ------------------------------------------------------------------
    int          if_left = 0, d_left = 0, if_k = 0, d_k = 0;
    logic [31:0] if_base = 0, d_base = 0, d_wdata_base = 0, rsp_data = 0;
    logic        d_we_k = 0;
    logic [3:0]  d_strb_k = 0;
    int          gnt_delay = 0, rsp_delay = 1;
    bit          never_gnt = 0;

    // Requesters and memory responder, driven 1 time unit after posedge.
    initial begin : g_driver
        int  gw, rc;
        bit  seen, ig, dg;
        gw = 0; rc = 0; seen = 0;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
        d_wdata = 0; d_wstrb = 0; m_gnt = 0; m_rvalid = 0; m_rdata = 0;
        forever begin
            @(negedge clk);
            ig = if_gnt;
            dg = d_gnt;
            @(posedge clk);
            #1;
            if (ig) begin if_left--; if_k++; end
            if (dg) begin d_left--;  d_k++;  end
            if_req = (if_left > 0);
            if_addr = if_req ? if_base + 32'(4 * if_k) : $urandom;
            d_req = (d_left > 0);
            if (d_req) begin
                d_we    = d_we_k;
                d_addr  = d_base + 32'(4 * d_k);
                d_wdata = d_wdata_base + 32'(d_k);
                d_wstrb = d_strb_k;
            end else begin
                d_we    = 1'($urandom);
                d_addr  = $urandom;
                d_wdata = $urandom;
                d_wstrb = 4'($urandom);
            end
            m_gnt = 0;
            m_rvalid = 0;
            m_rdata = $urandom;
            if (rc > 0) begin
                rc--;
                if (rc == 0) begin
                    m_rvalid = 1;
                    m_rdata  = rsp_data;
                    rsp_data = rsp_data + 1;
                end
            end
            if (!m_req) begin
                seen = 0;
            end else if (!never_gnt) begin
                if (!seen) begin seen = 1; gw = gnt_delay; end
                if (gw == 0) begin m_gnt = 1; seen = 0; rc = rsp_delay; end
                else gw--;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transaction-level reference model, compared every cycle at negedge.
    // ------------------------------------------------------------------
    bit          mdl_live, mdl_acc, mdl_fetch, mdl_we;
    logic [31:0] mdl_addr, mdl_wdata;
    logic [3:0]  mdl_strb;
    int          mdl_age, mdl_starve;
    bit          mdl_ifv, mdl_dv, mdl_to;
    logic [31:0] mdl_rdata;

    always @(negedge clk) begin : g_model
        bit fw, dw;
        if (rst) begin
            mdl_live = 0; mdl_acc = 0; mdl_starve = 0; mdl_age = 0;
            mdl_ifv = 0; mdl_dv = 0; mdl_to = 0;
            chk("rst if_gnt", 32'(if_gnt), 0);
            chk("rst d_gnt", 32'(d_gnt), 0);
            chk("rst if_rvalid", 32'(if_rvalid), 0);
            chk("rst d_rvalid", 32'(d_rvalid), 0);
            chk("rst m_req", 32'(m_req), 0);
            chk("rst m_we", 32'(m_we), 0);
            chk("rst m_addr", m_addr, 0);
            chk("rst m_wdata", m_wdata, 0);
            chk("rst m_wstrb", 32'(m_wstrb), 0);
            chk("rst rdata", rdata, 0);
            chk("rst busy", 32'(busy), 0);
            chk("rst timeout_err", 32'(timeout_err), 0);
        end else begin
            fw = !mdl_live && if_req && (!d_req || mdl_starve == c_LIMIT);
            dw = !mdl_live && d_req && !fw;
            chk("mdl if_gnt", 32'(if_gnt), 32'(fw));
            chk("mdl d_gnt", 32'(d_gnt), 32'(dw));
            chk("mdl busy", 32'(busy), 32'(mdl_live));
            chk("mdl m_req", 32'(m_req), 32'(mdl_live && !mdl_acc));
            chk("mdl if_rvalid", 32'(if_rvalid), 32'(mdl_ifv));
            chk("mdl d_rvalid", 32'(d_rvalid), 32'(mdl_dv));
            chk("mdl timeout_err", 32'(timeout_err), 32'(mdl_to));
            if (mdl_live && !mdl_acc) begin
                chk("mdl m_we", 32'(m_we), 32'(mdl_we));
                chk("mdl m_addr", m_addr, mdl_addr);
                chk("mdl m_wstrb", 32'(m_wstrb), 32'(mdl_strb));
                if (mdl_we) chk("mdl m_wdata", m_wdata, mdl_wdata);
            end
            if (mdl_ifv || mdl_dv) chk("mdl rdata", rdata, mdl_rdata);
            // advance to the next cycle
            mdl_ifv = 0; mdl_dv = 0; mdl_to = 0;
            if (mdl_live) begin
                mdl_age++;
                if (mdl_age == c_TO) begin
                    mdl_live = 0; mdl_to = 1; mdl_rdata = 32'hFFFF_FFFF;
                    mdl_ifv = mdl_fetch; mdl_dv = !mdl_fetch;
                end else if (!mdl_acc) begin
                    if (m_gnt) mdl_acc = 1;
                end else if (m_rvalid) begin
                    mdl_live = 0; mdl_rdata = m_rdata;
                    mdl_ifv = mdl_fetch; mdl_dv = !mdl_fetch;
                end
            end else if (fw || dw) begin
                mdl_live = 1; mdl_acc = 0; mdl_age = 0; mdl_fetch = fw;
                mdl_we   = dw ? d_we : 1'b0;
                mdl_addr = fw ? if_addr : d_addr;
                mdl_wdata = d_wdata;
                mdl_strb = (dw && d_we) ? d_wstrb : 4'h0;
                if (fw || !if_req) mdl_starve = 0;
                else if (mdl_starve < c_LIMIT) mdl_starve++;
            end
        end
    end

    initial begin : g_watchdog
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog: got no finish expected finish within 5000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin : g_main
        string seq;
        int    rv_cnt;
        rst = 1'b1;
        settle(3);
        chk("reset busy", 32'(busy), 0);
        chk("reset m_req", 32'(m_req), 0);
        #2 rst = 1'b0;
        settle(2);
        chk("post-reset busy", 32'(busy), 0);

        // 1: lone fetch, fastest memory
        #2; rsp_data = 32'h0050_0093; gnt_delay = 0; rsp_delay = 1;
        if_base = 32'h100; if_k = 0; if_left = 1;
        @(negedge clk); chk("t1 if_gnt@0", 32'(if_gnt), 1);
        @(negedge clk); chk("t1 m_req@1", 32'(m_req), 1);
                        chk("t1 m_addr", m_addr, 32'h100);
                        chk("t1 m_we", 32'(m_we), 0);
        @(negedge clk);
        @(negedge clk); chk("t1 if_rvalid@3", 32'(if_rvalid), 1);
                        chk("t1 rdata", rdata, 32'h0050_0093);
        settle(4);

        // 2: simultaneous requests, data store wins first
        #2; rsp_data = 32'h1111_0000;
        d_base = 32'h2000; d_k = 0; d_we_k = 1; d_wdata_base = 32'hCAFE_F00D; d_strb_k = 4'hF;
        if_base = 32'h400; if_k = 0; d_left = 1; if_left = 1;
        @(negedge clk); chk("t2 d_gnt@0", 32'(d_gnt), 1);
                        chk("t2 if_gnt@0", 32'(if_gnt), 0);
        @(negedge clk); chk("t2 m_we", 32'(m_we), 1);
                        chk("t2 m_addr", m_addr, 32'h2000);
                        chk("t2 m_wdata", m_wdata, 32'hCAFE_F00D);
                        chk("t2 m_wstrb", 32'(m_wstrb), 32'hF);
        @(negedge clk);
        @(negedge clk); chk("t2 d_rvalid@3", 32'(d_rvalid), 1);
                        chk("t2 if_gnt@3", 32'(if_gnt), 1);
                        chk("t2 rdata", rdata, 32'h1111_0000);
        settle(6);

        // 3: starvation forcing, loads
        #2; d_base = 32'h5000; d_k = 0; d_we_k = 0; d_strb_k = 4'hF;
        if_base = 32'h600; if_k = 0; d_left = 6; if_left = 1;
        seq = "";
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if_gnt) seq = {seq, "F"};
            if (d_gnt)  seq = {seq, "D"};
        end
        n_checks++;
        if (seq != "DDDDFDD") begin
            n_err++;
            $display("FAIL t3 grant order: got %s expected DDDDFDD", seq);
        end
        settle(2);

        // 4: memory never accepts -> timeout abort
        #2; never_gnt = 1; if_base = 32'h800; if_k = 0; if_left = 1;
        @(negedge clk); chk("t4 if_gnt@0", 32'(if_gnt), 1);
        for (int i = 1; i <= c_TO; i++) begin
            @(negedge clk); chk($sformatf("t4 m_req@%0d", i), 32'(m_req), 1);
        end
        @(negedge clk); chk("t4 m_req dropped", 32'(m_req), 0);
                        chk("t4 timeout_err", 32'(timeout_err), 1);
                        chk("t4 if_rvalid", 32'(if_rvalid), 1);
                        chk("t4 rdata ones", rdata, 32'hFFFF_FFFF);
                        chk("t4 busy", 32'(busy), 0);
        #2; never_gnt = 0;
        settle(3);

        // 5: reset during WAIT, stray response afterwards
        #2; rsp_delay = 10; d_base = 32'h6000; d_k = 0; d_we_k = 0; d_left = 1;
        @(negedge clk); chk("t5 d_gnt@0", 32'(d_gnt), 1);
        @(negedge clk);
        @(negedge clk); chk("t5 busy in WAIT", 32'(busy), 1);
                        chk("t5 m_req in WAIT", 32'(m_req), 0);
        @(posedge clk); #2 rst = 1'b1;
        #1;             chk("t5 busy at rst", 32'(busy), 0);
                        chk("t5 m_wstrb at rst", 32'(m_wstrb), 0);
                        chk("t5 m_addr at rst", m_addr, 0);
        @(negedge clk); #2 rst = 1'b0;
        rv_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (d_rvalid || if_rvalid || busy) rv_cnt++;
        end
        chk("t5 stray ignored", 32'(rv_cnt), 0);
        #2; rsp_delay = 1;
        settle(2);

        // 6: stalled accept with moving data-port inputs
        #2; gnt_delay = 3; d_base = 32'h3000; d_k = 0; d_we_k = 1;
        d_wdata_base = 32'h1234_5678; d_strb_k = 4'h5; d_left = 1;
        @(negedge clk); chk("t6 d_gnt@0", 32'(d_gnt), 1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk($sformatf("t6 m_req@%0d", i), 32'(m_req), 1);
            chk($sformatf("t6 m_addr@%0d", i), m_addr, 32'h3000);
            chk($sformatf("t6 m_wdata@%0d", i), m_wdata, 32'h1234_5678);
            chk($sformatf("t6 m_wstrb@%0d", i), 32'(m_wstrb), 32'h5);
        end
        #2; gnt_delay = 0;
        settle(8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
